// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op codes, FSM states and the flag bundle.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_SLL   = 4'b0100;
   localparam logic [3:0] OP_SRL   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_PASSB = 4'b0111;
   localparam logic [3:0] OP_SRA   = 4'b1000;
   localparam logic [3:0] OP_SLT   = 4'b1001;
   localparam logic [3:0] OP_SLTU  = 4'b1010;
   localparam logic [3:0] OP_MUL   = 4'b1011;
   localparam logic [3:0] OP_NOR   = 4'b1100;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } alu_state_e;

   typedef struct packed {
      logic zero;
      logic carry;
      logic overflow;
      logic negative;
   } alu_flags_t;

endpackage

// File: rtl/pipelined_alu_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and writeback.
interface pipelined_alu_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alu_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             negative;

   modport master (
      output in_valid, a, b, alu_sel, out_ready,
      input  in_ready, out_valid, result, zero, carry, overflow, negative
   );

   modport slave (
      input  in_valid, a, b, alu_sel, out_ready,
      output in_ready, out_valid, result, zero, carry, overflow, negative
   );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, low WIDTH product bits.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] mcand_in,
   input  logic [WIDTH-1:0] mplier_in,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);

   logic             busy_p1;
   logic [CW-1:0]    cnt_p1;
   logic [WIDTH-1:0] mcand_p1;
   logic [WIDTH-1:0] mplier_p1;
   logic [WIDTH-1:0] acc_p1;
   logic [WIDTH-1:0] acc_next;

   // The final iteration's sum is presented directly so the result lands on that same edge.
   assign acc_next = mplier_p1[0] ? acc_p1 + mcand_p1 : acc_p1;
   assign done     = busy_p1 && (cnt_p1 == CW'(WIDTH - 1));
   assign product  = acc_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_p1   <= 1'b0;
         cnt_p1    <= '0;
         mcand_p1  <= '0;
         mplier_p1 <= '0;
         acc_p1    <= '0;
      end else if (start) begin
         busy_p1   <= 1'b1;
         cnt_p1    <= '0;
         mcand_p1  <= mcand_in;
         mplier_p1 <= mplier_in;
         acc_p1    <= '0;
      end else if (busy_p1) begin
         acc_p1    <= acc_next;
         mcand_p1  <= mcand_p1 << 1;
         mplier_p1 <= mplier_p1 >> 1;
         cnt_p1    <= cnt_p1 + 1'b1;
         if (done) busy_p1 <= 1'b0;
      end
   end
endmodule

// File: rtl/pipelined_alu.sv
// Registered ALU with valid/ready handshakes, NZCV-style flags and an iterative MUL.
module pipelined_alu
   import alu_pkg::*;
#(
   parameter  int WIDTH = 64,
   localparam int SHW   = $clog2(WIDTH)
) (
   input logic            clk,
   input logic            reset,
   pipelined_alu_if.slave bus
);
   alu_state_e       state_p, state_d;
   logic             vld_p;
   logic [WIDTH-1:0] result_p;
   alu_flags_t       flags_p;

   logic             accept, mul_start, load_alu, mul_done;
   logic [WIDTH-1:0] mul_prod;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   add_sum, sub_sum;
   logic [WIDTH-1:0] res_d, load_res;
   logic             carry_d, ovf_d;
   alu_flags_t       load_flags;

   assign bus.in_ready = !reset && (state_p == IDLE) && (!vld_p || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign mul_start    = accept && (bus.alu_sel == OP_MUL);
   assign load_alu     = accept && (bus.alu_sel != OP_MUL);

   assign shamt   = bus.b[SHW-1:0];
   assign add_sum = {1'b0, bus.a} + {1'b0, bus.b};
   assign sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start     (mul_start),
      .mcand_in  (bus.a),
      .mplier_in (bus.b),
      .done      (mul_done),
      .product   (mul_prod)
   );

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (bus.alu_sel)
         OP_AND:   res_d = bus.a & bus.b;
         OP_OR:    res_d = bus.a | bus.b;
         OP_XOR:   res_d = bus.a ^ bus.b;
         OP_NOR:   res_d = ~(bus.a | bus.b);
         OP_PASSB: res_d = bus.b;
         OP_SLL:   res_d = bus.a << shamt;
         OP_SRL:   res_d = bus.a >> shamt;
         OP_SRA:   res_d = $signed(bus.a) >>> shamt;
         OP_SLT:   res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU:  res_d = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         OP_ADD: begin
            res_d   = add_sum[WIDTH-1:0];
            carry_d = add_sum[WIDTH];
            ovf_d   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            res_d   = sub_sum[WIDTH-1:0];
            carry_d = sub_sum[WIDTH];
            ovf_d   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         default:  res_d = '0;
      endcase
   end

   // mul_done only occurs in MUL state, where no new operand can be accepted.
   always_comb begin
      load_res   = mul_done ? mul_prod : res_d;
      load_flags = '{zero:     (load_res == '0),
                     carry:    !mul_done && carry_d,
                     overflow: !mul_done && ovf_d,
                     negative: load_res[WIDTH-1]};
   end

   always_comb begin
      state_d = state_p;
      case (state_p)
         IDLE: if (mul_start) state_d = MUL;
         MUL:  if (mul_done)  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_p <= IDLE;
      else       state_p <= state_d;
   end

   // Output stage: holds while stalled, replaced on a simultaneous transfer and accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p    <= 1'b0;
         result_p <= '0;
         flags_p  <= '0;
      end else if (load_alu || mul_done) begin
         vld_p    <= 1'b1;
         result_p <= load_res;
         flags_p  <= load_flags;
      end else if (vld_p && bus.out_ready) begin
         vld_p    <= 1'b0;
      end
   end

   assign bus.out_valid = vld_p;
   assign bus.result    = result_p;
   assign bus.zero      = flags_p.zero;
   assign bus.carry     = flags_p.carry;
   assign bus.overflow  = flags_p.overflow;
   assign bus.negative  = flags_p.negative;
endmodule
